ctrl_seq: RTL
=============

Name: ctrl_seq

Overview:
- Parametrised multi-cycle instruction sequencer for the 16-bit RISC core; successor to the fixed 6-stage one-hot control unit.
- Drives one-hot stage enables: fetch, decode, register read, ALU, register write, memory by default.
- Adds a global stall, per-stage wait-for-done handshakes, decode-driven stage skipping, a halt/resume state and a retired-instruction counter.
- Sits between the datapath stage blocks and the top level.

Parameters:
- NUM_STAGES, 6: number of one-hot stages (min 3).
- DEC_STAGE, 1: index of the decode stage; the skip mask and halt flag are sampled when this stage advances.
- WAIT_MASK, 6'b100000: bit k=1 means stage k holds until I_stagedone[k]. Default: memory waits.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- I_clk  in  1  clock.
- I_reset  in  1  synchronous, active-high reset.
- I_stall  in  1  global hold; freezes the sequencer.
- I_stagedone  in  NUM_STAGES  per-stage completion; only honoured for WAIT_MASK stages.
- I_skipmask  in  NUM_STAGES  stages the decoded instruction does not need; sampled with I_halt.
- I_halt  in  1  decoded instruction is HALT.
- I_resume  in  1  leave halted state.
- O_en  out  NUM_STAGES  one-hot stage enables.
- O_stage  out  $clog2(NUM_STAGES)  binary index of the active stage; 0 when halted.
- O_halted  out  1  sequencer is in HALT.
- O_retire  out  1  one-cycle pulse when an instruction completes.
- O_instcount  out  CNT_W  retired instruction count.

Behaviour:
Reset (I_clk edge with I_reset=1) has priority over everything. It sets:
- O_en=…0001, O_stage=0, O_halted=0, O_retire=0, O_instcount=0.
- skip_q=0, halt_q=0.
Reset mid-instruction abandons that instruction; it is not counted.

Registered state: one-hot stage vector plus a HALT flag. All outputs are registered or a direct decode of the state. There is no combinational path from inputs to O_en.

Advance condition for active stage k: !I_stall && (!WAIT_MASK[k] || I_stagedone[k]).
- I_stagedone is ignored while stalled. The producer must hold done until it sees the advance.
- If the condition is false, the state holds and O_en is unchanged.

Next stage on advance:
- Select the lowest j>k with skip_q[j]==0.
- If no such j exists, wrap: the next state is stage 0, or HALT if halt_q=1.
- On wrap: O_retire=1 for exactly the next cycle, O_instcount+1 (modulo 2^CNT_W, wraps silently), skip_q cleared, halt_q cleared.

Sampling at decode:
- When stage DEC_STAGE advances, skip_q <= I_skipmask with bits [DEC_STAGE:0] forced 0, and halt_q <= I_halt.
- The next-stage selection at that edge already uses the new mask, so stage DEC_STAGE+1 can itself be skipped.
- Skipped stages never assert O_en.

HALT state:
- O_en=0, O_halted=1, O_stage=0.
- Exit when I_resume && !I_stall: go to stage 0 on the next cycle, O_halted=0.
- I_resume outside HALT is ignored.
- A halting instruction still completes its unskipped stages and is counted.

Illegal (non-one-hot) state: recover to stage 0 on the next edge. No retire, no count.

Latency, no skips/stalls/waits: NUM_STAGES cycles per instruction. The retire pulse coincides with the cycle O_en returns to stage 0.

Decomposition:
- Package ctrl_seq_pkg holds:
  - default stage index constants STG_FETCH=0, STG_DEC=1, STG_RGRD=2, STG_ALU=3, STG_RGWR=4, STG_MEM=5;
  - NUM_STAGES_DEF=6;
  - the default WAIT_MASK constant.
- One sub-module, ctrl_next_stage: purely combinational. Takes the current one-hot vector and skip_q, returns the next one-hot vector and a wrap flag (a priority search above k). This is the unit-testable core.

Test Plan:
1. Reset, then free-run with I_stagedone[5]=1 held and no skips → O_en steps 000001→000010→…→100000→000001. O_retire pulses every 6th cycle; O_instcount=3 after 18 cycles.
2. I_skipmask=6'b110000 at decode → sequence 000001,000010,000100,001000, then wrap to 000001. Instruction takes 4 cycles, O_retire pulses, count+1. The next instruction's mask is clean.
3. In stage 5 (memory), hold I_stagedone[5]=0 for 3 cycles, then 1 → O_en stays 100000 for 4 cycles total, then 000001. The count increments once.
4. Assert I_stall for 2 cycles during stage 3 (ALU), with I_stagedone raised meanwhile → O_en frozen at 001000 for 2 extra cycles, then advances normally.
5. I_halt=1 at decode with I_skipmask=0 → stages 2–5 complete, O_retire pulses, O_halted=1, O_en=0. Hold I_resume=0 for 5 cycles: state unchanged. Raise I_resume: next cycle O_en=000001, O_halted=0.
6. Assert I_reset while in stage 4, and separately while halted → next cycle O_en=000001 and O_instcount=0. With CNT_W=4, 16 retirements return O_instcount to 0.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared constants for the multi-cycle instruction sequencer: default stage
// indices, default stage count and the default wait-for-done mask.
package ctrl_seq_pkg;

  localparam int unsigned STG_FETCH      = 0;
  localparam int unsigned STG_DEC        = 1;
  localparam int unsigned STG_RGRD       = 2;
  localparam int unsigned STG_ALU        = 3;
  localparam int unsigned STG_RGWR       = 4;
  localparam int unsigned STG_MEM        = 5;
  localparam int unsigned NUM_STAGES_DEF = 6;

  // Only the memory stage waits for its datapath block by default.
  localparam logic [NUM_STAGES_DEF-1:0] WAIT_MASK_DEF = 6'b100000;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_HALT = 1'b1
  } mode_e;

endpackage

// File: rtl/ctrl_next_stage.sv
// Combinational next-stage search: lowest unskipped stage above the active one,
// or a wrap flag when no such stage exists.
module ctrl_next_stage
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = NUM_STAGES_DEF
) (
  input  logic [NUM_STAGES-1:0] I_cur,
  input  logic [NUM_STAGES-1:0] I_skip,
  output logic [NUM_STAGES-1:0] O_next_c,
  output logic                  O_wrap_c
);

  logic seen_c;
  logic found_c;

  // Priority search: only stages strictly above the active bit are candidates.
  always_comb begin
    O_next_c = '0;
    seen_c   = 1'b0;
    found_c  = 1'b0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      if (seen_c && !found_c && !I_skip[j]) begin
        O_next_c[j] = 1'b1;
        found_c     = 1'b1;
      end
      if (I_cur[j]) begin
        seen_c = 1'b1;
      end
    end
    O_wrap_c = !found_c;
  end

endmodule

// File: rtl/ctrl_seq.sv
// Parametrised one-hot instruction sequencer with global stall, per-stage
// done handshakes, decode-driven stage skipping, HALT/resume and retire count.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned            NUM_STAGES = NUM_STAGES_DEF,
  parameter int unsigned            DEC_STAGE  = STG_DEC,
  parameter logic [NUM_STAGES-1:0]  WAIT_MASK  = WAIT_MASK_DEF,
  parameter int unsigned            CNT_W      = 16,
  localparam int unsigned           STAGE_W    = $clog2(NUM_STAGES)
) (
  input  logic                  I_clk,
  input  logic                  I_reset,
  input  logic                  I_stall,
  input  logic [NUM_STAGES-1:0] I_stagedone,
  input  logic [NUM_STAGES-1:0] I_skipmask,
  input  logic                  I_halt,
  input  logic                  I_resume,
  output logic [NUM_STAGES-1:0] O_en,
  output logic [STAGE_W-1:0]    O_stage,
  output logic                  O_halted,
  output logic                  O_retire,
  output logic [CNT_W-1:0]      O_instcount
);

  // Stages at or below decode can never be skipped by the decoded instruction.
  localparam logic [NUM_STAGES-1:0] DEC_KEEP =
    ~((NUM_STAGES'(1) << (DEC_STAGE + 1)) - NUM_STAGES'(1));

  function automatic logic is_onehot(input logic [NUM_STAGES-1:0] v);
    return (v != '0) && ((v & (v - NUM_STAGES'(1))) == '0);
  endfunction

  function automatic logic [STAGE_W-1:0] enc(input logic [NUM_STAGES-1:0] v);
    logic [STAGE_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (v[i]) r = r | STAGE_W'(i);
    end
    return r;
  endfunction

  logic [NUM_STAGES-1:0] en_q, en_d;
  logic [STAGE_W-1:0]    stage_q, stage_d;
  mode_e                 mode_q, mode_d;
  logic [NUM_STAGES-1:0] skip_q, skip_d;
  logic                  halt_q, halt_d;
  logic                  retire_q, retire_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  at_dec_c;
  logic [NUM_STAGES-1:0] skip_eff_c;
  logic                  halt_eff_c;
  logic                  advance_c;
  logic [NUM_STAGES-1:0] next_c;
  logic                  wrap_c;

  ctrl_next_stage #(
    .NUM_STAGES (NUM_STAGES)
  ) u_next (
    .I_cur    (en_q),
    .I_skip   (skip_eff_c),
    .O_next_c (next_c),
    .O_wrap_c (wrap_c)
  );

  // Decode-time sampling feeds the search directly so DEC_STAGE+1 can be skipped.
  always_comb begin
    at_dec_c   = en_q[DEC_STAGE];
    skip_eff_c = at_dec_c ? (I_skipmask & DEC_KEEP) : skip_q;
    halt_eff_c = at_dec_c ? I_halt : halt_q;
    advance_c  = !I_stall && ((en_q & WAIT_MASK & ~I_stagedone) == '0);
  end

  // Next-state and output logic.
  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    skip_d   = skip_q;
    halt_d   = halt_q;
    retire_d = 1'b0;
    cnt_d    = cnt_q;

    if (mode_q == MODE_HALT) begin
      if (I_resume && !I_stall) begin
        mode_d = MODE_RUN;
        en_d   = NUM_STAGES'(1);
      end
    end else if (!is_onehot(en_q)) begin
      en_d   = NUM_STAGES'(1);
      skip_d = '0;
      halt_d = 1'b0;
    end else if (advance_c) begin
      skip_d = skip_eff_c;
      halt_d = halt_eff_c;
      if (wrap_c) begin
        retire_d = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        skip_d   = '0;
        halt_d   = 1'b0;
        if (halt_eff_c) begin
          mode_d = MODE_HALT;
          en_d   = '0;
        end else begin
          en_d = NUM_STAGES'(1);
        end
      end else begin
        en_d = next_c;
      end
    end

    stage_d = enc(en_d);
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      en_q     <= NUM_STAGES'(1);
      stage_q  <= '0;
      mode_q   <= MODE_RUN;
      skip_q   <= '0;
      halt_q   <= 1'b0;
      retire_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      en_q     <= en_d;
      stage_q  <= stage_d;
      mode_q   <= mode_d;
      skip_q   <= skip_d;
      halt_q   <= halt_d;
      retire_q <= retire_d;
      cnt_q    <= cnt_d;
    end
  end

  assign O_en        = en_q;
  assign O_stage     = stage_q;
  assign O_halted    = (mode_q == MODE_HALT);
  assign O_retire    = retire_q;
  assign O_instcount = cnt_q;

endmodule
